// File: rtl/proc_context_ctrl.sv
// Kernel/user register-bank context sequencer.
// Handles dispatch, syscall, I/O interrupt and time-slice preemption.
module proc_context_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned QW            = 16,
    parameter int unsigned OS_VECTOR     = 0,
    parameter int unsigned VEC_STRIDE    = 4,
    parameter int unsigned CAUSE_TIMER   = 1,
    parameter int unsigned CAUSE_SYSCALL = 2,
    parameter int unsigned CAUSE_IO_BASE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exec_proc_i,
    input  logic [DATA_WIDTH-1:0] target_pc_i,
    input  logic [QW-1:0]         quantum_i,
    input  logic [DATA_WIDTH-1:0] cur_pc_i,
    input  logic                  syscall_i,
    input  logic                  io_req_i,
    input  logic [3:0]            io_code_i,
    output logic                  io_ack_o,
    output logic                  rd_shft_enabler_o,
    output logic                  wrt_shft_enabler_o,
    output logic                  save_proc_pc_o,
    output logic [DATA_WIDTH-1:0] proc_pc_o,
    output logic                  pc_load_o,
    output logic [DATA_WIDTH-1:0] pc_target_o,
    output logic                  stall_o,
    output logic                  user_mode_o
);

    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        S_KERNEL,
        S_DISPATCH,
        S_USER,
        S_SAVE,
        S_VECTOR
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] resume_pc_q, resume_pc_d;
    logic [DATA_WIDTH-1:0] proc_pc_q, proc_pc_d;
    logic [QW-1:0]         cnt_q, cnt_d;
    logic                  qnz_q, qnz_d;
    logic [CW-1:0]         cause_q, cause_d;
    logic                  io_q, io_d;
    logic                  en_q, en_d;

    logic                  in_user;
    logic                  ev_sys;
    logic                  ev_io;
    logic                  ev_tmr;
    logic                  ev_any;
    logic [DATA_WIDTH-1:0] vec_pc;

    // Event decode in USER: syscall beats io beats timer.
    always_comb begin
        in_user = (state_q == S_USER);
        ev_sys  = in_user && syscall_i;
        ev_io   = in_user && !syscall_i && io_req_i;
        ev_tmr  = in_user && !syscall_i && !io_req_i
                  && qnz_q && (cnt_q == '0);
        ev_any  = ev_sys || ev_io || ev_tmr;
        vec_pc  = DATA_WIDTH'(OS_VECTOR)
                  + DATA_WIDTH'(cause_q) * DATA_WIDTH'(VEC_STRIDE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_KERNEL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_KERNEL:   if (exec_proc_i) state_d = S_DISPATCH;
            S_DISPATCH: state_d = S_USER;
            S_USER:     if (ev_any) state_d = S_SAVE;
            S_SAVE:     state_d = S_VECTOR;
            S_VECTOR:   state_d = S_KERNEL;
            default:    state_d = S_KERNEL;
        endcase
    end

    // Per-state output strobes.
    always_comb begin
        stall_o        = 1'b0;
        pc_load_o      = 1'b0;
        pc_target_o    = '0;
        save_proc_pc_o = 1'b0;
        io_ack_o       = 1'b0;
        unique case (state_q)
            S_DISPATCH: begin
                stall_o     = 1'b1;
                pc_load_o   = 1'b1;
                pc_target_o = resume_pc_q;
            end
            S_USER: begin
                stall_o = ev_io || ev_tmr;
            end
            S_SAVE: begin
                stall_o        = 1'b1;
                save_proc_pc_o = 1'b1;
                io_ack_o       = io_q;
            end
            S_VECTOR: begin
                stall_o     = 1'b1;
                pc_load_o   = 1'b1;
                pc_target_o = vec_pc;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    // Context datapath next values.
    always_comb begin
        resume_pc_d = resume_pc_q;
        cnt_d       = cnt_q;
        qnz_d       = qnz_q;
        proc_pc_d   = proc_pc_q;
        cause_d     = cause_q;
        io_d        = io_q;
        if (state_q == S_KERNEL && exec_proc_i) begin
            resume_pc_d = target_pc_i;
            cnt_d       = quantum_i;
            qnz_d       = (quantum_i != '0);
        end
        if (in_user && !ev_any && cnt_q != '0) begin
            cnt_d = cnt_q - QW'(1);
        end
        if (ev_any) begin
            io_d = ev_io;
            if (ev_sys) begin
                proc_pc_d = cur_pc_i + DATA_WIDTH'(1);
                cause_d   = CW'(CAUSE_SYSCALL);
            end else if (ev_io) begin
                proc_pc_d = cur_pc_i;
                cause_d   = CW'(CAUSE_IO_BASE) + CW'(io_code_i);
            end else begin
                proc_pc_d = cur_pc_i;
                cause_d   = CW'(CAUSE_TIMER);
            end
        end
        en_d = (state_d == S_DISPATCH) || (state_d == S_USER);
    end

    // Context registers and registered bank select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resume_pc_q <= '0;
            cnt_q       <= '0;
            qnz_q       <= 1'b0;
            proc_pc_q   <= '0;
            cause_q     <= '0;
            io_q        <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            resume_pc_q <= resume_pc_d;
            cnt_q       <= cnt_d;
            qnz_q       <= qnz_d;
            proc_pc_q   <= proc_pc_d;
            cause_q     <= cause_d;
            io_q        <= io_d;
            en_q        <= en_d;
        end
    end

    assign rd_shft_enabler_o  = en_q;
    assign wrt_shft_enabler_o = en_q;
    assign proc_pc_o          = proc_pc_q;
    assign user_mode_o        = in_user;

endmodule

// File: tb/tb_proc_context_ctrl.sv
// Self-checking bench for proc_context_ctrl.
// Directed scenarios followed by randomized dispatch sessions.
module tb_proc_context_ctrl;

    localparam int DW = 32;
    localparam int QW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          exec_proc_i;
    logic [DW-1:0] target_pc_i;
    logic [QW-1:0] quantum_i;
    logic [DW-1:0] cur_pc_i;
    logic          syscall_i;
    logic          io_req_i;
    logic [3:0]    io_code_i;
    logic          io_ack_o;
    logic          rd_shft_enabler_o;
    logic          wrt_shft_enabler_o;
    logic          save_proc_pc_o;
    logic [DW-1:0] proc_pc_o;
    logic          pc_load_o;
    logic [DW-1:0] pc_target_o;
    logic          stall_o;
    logic          user_mode_o;

    int checks = 0;
    int errors = 0;
    int m_q;
    int m_commits;

    always #5 clk = ~clk;

    proc_context_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .exec_proc_i       (exec_proc_i),
        .target_pc_i       (target_pc_i),
        .quantum_i         (quantum_i),
        .cur_pc_i          (cur_pc_i),
        .syscall_i         (syscall_i),
        .io_req_i          (io_req_i),
        .io_code_i         (io_code_i),
        .io_ack_o          (io_ack_o),
        .rd_shft_enabler_o (rd_shft_enabler_o),
        .wrt_shft_enabler_o(wrt_shft_enabler_o),
        .save_proc_pc_o    (save_proc_pc_o),
        .proc_pc_o         (proc_pc_o),
        .pc_load_o         (pc_load_o),
        .pc_target_o       (pc_target_o),
        .stall_o           (stall_o),
        .user_mode_o       (user_mode_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_pc_load"}, pc_load_o, 0);
        chk({tag, "_pc_target"}, pc_target_o, 0);
        chk({tag, "_save"}, save_proc_pc_o, 0);
        chk({tag, "_ack"}, io_ack_o, 0);
        chk({tag, "_rd_en"}, rd_shft_enabler_o, 0);
        chk({tag, "_wr_en"}, wrt_shft_enabler_o, 0);
        chk({tag, "_user"}, user_mode_o, 0);
    endtask

    // Entered just after a rising edge while the DUT sits in KERNEL.
    task automatic dispatch(input logic [31:0] tgt, input int q);
        exec_proc_i = 1'b1;
        target_pc_i = tgt;
        quantum_i   = QW'(q);
        syscall_i   = 1'b1;
        @(negedge clk);
        chk("kern_user", user_mode_o, 0);
        chk("kern_stall", stall_o, 0);
        chk("kern_pc_load", pc_load_o, 0);
        chk("kern_ack", io_ack_o, 0);
        chk("kern_en", rd_shft_enabler_o, 0);
        @(posedge clk); #1;
        exec_proc_i = 1'b0;
        syscall_i   = 1'b0;
        target_pc_i = $urandom;
        quantum_i   = QW'($urandom);
        @(negedge clk);
        chk("disp_pc_load", pc_load_o, 1);
        chk("disp_target", pc_target_o, tgt);
        chk("disp_stall", stall_o, 1);
        chk("disp_rd_en", rd_shft_enabler_o, 1);
        chk("disp_wr_en", wrt_shft_enabler_o, 1);
        chk("disp_user", user_mode_o, 0);
        @(posedge clk); #1;
        m_q       = q;
        m_commits = 0;
    endtask

    // One USER cycle; runs SAVE and VECTOR when an event is expected.
    task automatic user_cycle(input logic [31:0] pc, input bit sys,
                              input bit io, input logic [3:0] code,
                              input bit keep_io, output bit ended);
        int          ev;
        int          cause;
        logic [31:0] epc;
        cur_pc_i    = pc;
        syscall_i   = sys;
        io_req_i    = io;
        io_code_i   = code;
        exec_proc_i = 1'($urandom_range(0, 1));
        target_pc_i = $urandom;
        if (sys) ev = 1;
        else if (io) ev = 2;
        else if (m_q != 0 && m_commits == m_q) ev = 3;
        else ev = 0;
        @(negedge clk);
        chk("user_mode", user_mode_o, 1);
        chk("user_en", rd_shft_enabler_o & wrt_shft_enabler_o, 1);
        chk("user_pc_load", pc_load_o, 0);
        chk("user_stall", stall_o, (ev == 2 || ev == 3) ? 1 : 0);
        @(posedge clk); #1;
        syscall_i = 1'b0;
        if (ev == 0) begin
            exec_proc_i = 1'b0;
            m_commits++;
            ended = 1'b0;
            return;
        end
        epc = (ev == 1) ? pc + 32'd1 : pc;
        if (ev == 1) cause = 2;
        else if (ev == 2) cause = 8 + int'(code);
        else cause = 1;
        exec_proc_i = 1'b1;
        io_req_i    = io && (ev == 2 || keep_io);
        @(negedge clk);
        chk("save_strobe", save_proc_pc_o, 1);
        chk("save_proc_pc", proc_pc_o, epc);
        chk("save_en", rd_shft_enabler_o | wrt_shft_enabler_o, 0);
        chk("save_stall", stall_o, 1);
        chk("save_ack", io_ack_o, (ev == 2) ? 1 : 0);
        chk("save_pc_load", pc_load_o, 0);
        @(posedge clk); #1;
        exec_proc_i = 1'b0;
        if (ev == 2) io_req_i = 1'b0;
        @(negedge clk);
        chk("vec_pc_load", pc_load_o, 1);
        chk("vec_target", pc_target_o, 32'(cause * 4));
        chk("vec_stall", stall_o, 1);
        chk("vec_save", save_proc_pc_o, 0);
        chk("vec_ack", io_ack_o, 0);
        chk("vec_en", rd_shft_enabler_o, 0);
        @(posedge clk); #1;
        ended = 1'b1;
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ended;
        logic [31:0] pc;
        bit          sys;
        bit          io;
        int          n;

        rst_n       = 1'b0;
        exec_proc_i = 1'b0;
        target_pc_i = '0;
        quantum_i   = '0;
        cur_pc_i    = '0;
        syscall_i   = 1'b0;
        io_req_i    = 1'b0;
        io_code_i   = '0;
        #12;
        chk_all_zero("reset");
        chk("reset_proc_pc", proc_pc_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // quantum 0: no preemption over 100 cycles, then syscall
        dispatch(32'h40, 0);
        for (int i = 0; i < 100; i++) begin
            user_cycle(32'h40 + 32'(i), 0, 0, 0, 0, ended);
        end
        chk("q0_no_preempt", ended, 0);
        user_cycle(32'h45, 1, 0, 0, 0, ended);
        chk("sys_ended", ended, 1);

        // quantum 3: three commits, fourth USER cycle preempted
        dispatch(32'h100, 3);
        for (int i = 0; i < 4; i++) begin
            user_cycle(32'h100 + 32'(i), 0, 0, 0, 0, ended);
            chk("q3_timer_edge", ended, (i == 3) ? 1 : 0);
        end

        // io code 2, dropped after ack: no re-entry
        dispatch(32'h200, 0);
        user_cycle(32'h210, 0, 1, 4'd2, 0, ended);
        chk("io_ended", ended, 1);
        dispatch(32'h300, 0);
        user_cycle(32'h300, 0, 0, 0, 0, ended);
        chk("io_no_reentry", ended, 0);
        user_cycle(32'h301, 1, 0, 0, 0, ended);

        // syscall and io together: syscall first, io pends
        dispatch(32'h400, 0);
        user_cycle(32'h404, 1, 1, 4'd5, 1, ended);
        chk("sys_io_ended", ended, 1);
        dispatch(32'h500, 0);
        user_cycle(32'h500, 0, 1, 4'd5, 0, ended);
        chk("io_pend_taken", ended, 1);

        // io pulse in KERNEL dropped before dispatch
        io_req_i  = 1'b1;
        io_code_i = 4'd7;
        @(negedge clk);
        chk("kern_io_masked_stall", stall_o, 0);
        chk("kern_io_masked_ack", io_ack_o, 0);
        @(posedge clk); #1;
        io_req_i = 1'b0;
        dispatch(32'h600, 0);
        user_cycle(32'h600, 0, 0, 0, 0, ended);
        chk("kern_io_dropped", ended, 0);
        user_cycle(32'h601, 1, 0, 0, 0, ended);

        // PC wrap on syscall
        dispatch(32'h700, 0);
        user_cycle(32'hFFFF_FFFF, 1, 0, 0, 0, ended);

        // reset asserted during SAVE
        dispatch(32'h800, 0);
        cur_pc_i  = 32'h810;
        syscall_i = 1'b1;
        @(posedge clk); #1;
        syscall_i = 1'b0;
        #2;
        chk("pre_rst_save", save_proc_pc_o, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_save_rst");
        chk("mid_save_rst_proc_pc", proc_pc_o, 0);
        @(posedge clk); #1;
        chk("rst_no_vector", pc_load_o, 0);
        chk("rst_bank0", rd_shft_enabler_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dispatch(32'h900, 2);
        user_cycle(32'h900, 1, 0, 0, 0, ended);

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            dispatch($urandom, $urandom_range(0, 4));
            ended = 1'b0;
            n     = 0;
            while (!ended) begin
                pc  = $urandom;
                if (s % 8 == 7) pc = 32'hFFFF_FFFF;
                sys = (n == 12) || ($urandom_range(0, 7) == 0);
                io  = io_req_i || ($urandom_range(0, 9) == 0);
                user_cycle(pc, sys, io, 4'($urandom),
                           1'($urandom_range(0, 1)), ended);
                n++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_context_ctrl.md
Name: proc_context_ctrl

Overview:
- Sequences register-bank switching between OS (kernel) and user process contexts for the banked register file.
- Drives the bank-select enablers, the proc-PC save strobe and PC redirects.
- Handles OS dispatch, syscall, external I/O interrupt and time-slice preemption.
- Sits between decode/PC logic and the register file; kernel bank = 0, process bank = 1.

Parameters:
- DATA_WIDTH, 32, datapath/PC width.
- QW, 16, quantum counter width.
- OS_VECTOR, 0, base PC of OS entry table.
- VEC_STRIDE, 4, words between entry vectors.
- CAUSE_TIMER, 1, timer cause id.
- CAUSE_SYSCALL, 2, syscall cause id.
- CAUSE_IO_BASE, 8, I/O cause id = CAUSE_IO_BASE + io_code.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- exec_proc  in  1  OS dispatch request; honoured in KERNEL only.
- target_pc  in  DATA_WIDTH  process resume PC, sampled with exec_proc.
- quantum  in  QW  time slice in USER cycles, sampled with exec_proc; 0 = no preemption.
- cur_pc  in  DATA_WIDTH  PC of the instruction currently executing.
- syscall  in  1  decoded syscall in the current instruction.
- io_req  in  1  external interrupt level; held until io_ack.
- io_code  in  4  I/O source id.
- io_ack  out  1  one-cycle acknowledge of io_req.
- rd_shft_enabler  out  1  read bank select.
- wrt_shft_enabler  out  1  write bank select.
- save_proc_pc  out  1  strobe: write proc_pc into kernel $2.
- proc_pc  out  DATA_WIDTH  saved process PC.
- pc_load  out  1  PC redirect strobe.
- pc_target  out  DATA_WIDTH  redirect target.
- stall  out  1  suppress commit/PC advance this cycle.
- user_mode  out  1  1 while in USER.

Behaviour:
Reset (async, rst_n=0):
- State goes to KERNEL.
- All outputs 0; resume_pc, proc_pc, cause and counter are 0.

States: KERNEL, DISPATCH, USER, SAVE, VECTOR.
- Enablers are registered: both 1 in DISPATCH and USER, 0 otherwise. user_mode = (state==USER).

KERNEL:
- syscall and io_req are masked; io_req stays pending.
- On exec_proc: latch resume_pc=target_pc and cnt=quantum; go to DISPATCH.

DISPATCH (1 cycle):
- stall=1, pc_load=1, pc_target=resume_pc; go to USER.

USER:
- Event priority: syscall > io_req > timer. Timer fires when quantum!=0 and cnt==0.
- No event: cnt decrements if nonzero. Quantum Q therefore commits exactly Q user instructions.
- syscall: the instruction commits (stall=0); latch proc_pc=cur_pc+1 and cause=CAUSE_SYSCALL.
- io/timer: stall=1 in the event cycle, so the instruction is not committed; latch proc_pc=cur_pc and cause accordingly.
- Any event: go to SAVE.

SAVE (1 cycle):
- stall=1, save_proc_pc=1, enablers=0 so the write lands in the kernel bank.
- io_ack=1 if the cause is I/O; go to VECTOR.

VECTOR (1 cycle):
- stall=1, pc_load=1, pc_target=OS_VECTOR + cause*VEC_STRIDE (truncated to DATA_WIDTH); go to KERNEL.

Arithmetic: cur_pc+1 wraps modulo 2^DATA_WIDTH.

Boundary conditions:
- io_req deasserted before being taken: dropped, no ack.
- io_req asserted in SAVE/VECTOR/KERNEL: taken in the first USER cycle after the next dispatch.
- exec_proc outside KERNEL: ignored.
- syscall and io_req in the same USER cycle: syscall taken; io pends.
- Reset mid-SAVE/VECTOR: no further strobes; next state KERNEL, bank 0.

Test Plan:
- Reset, then exec_proc with target_pc=0x40, quantum=0 → DISPATCH pc_load=1/pc_target=0x40, stall=1; enablers=1 from the next cycle; no preemption over 100 cycles.
- USER with cur_pc=0x45 and syscall=1 → stall=0 that cycle; SAVE save_proc_pc=1, proc_pc=0x46, enablers=0; VECTOR pc_target=8 (cause 2 × 4).
- quantum=3 → exactly 3 non-stalled USER cycles; 4th USER cycle stall=1; proc_pc=that cur_pc; VECTOR pc_target=4.
- io_req=1 with io_code=2 in USER → SAVE io_ack=1 for one cycle; pc_target=(8+2)*4=40; io_req dropped after ack → no re-entry after next dispatch.
- syscall and io_req together in USER → syscall vector first, io_ack=0; after re-dispatch, io taken in the first USER cycle.
- rst_n low during SAVE → outputs 0 immediately, no VECTOR pc_load; exec_proc after release dispatches normally.
